// File: rtl/bitmask_enc_pkg.sv
// Shared constants, FSM state type and popcount helper for the bitmask index encoder.
package bitmask_enc_pkg;

  localparam int unsigned W  = 64;
  localparam int unsigned IW = 6;
  localparam int unsigned CW = 7;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StEmpty
  } state_e;

  function automatic logic [CW-1:0] popcount(input logic [W-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < W; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/bitmask_index_encoder_if.sv
// Input vector handshake and output index-beat handshake of the bitmask index encoder.
interface bitmask_index_encoder_if;
  import bitmask_enc_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_vec;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          out_empty;
  logic [CW-1:0] out_total;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_last, out_empty, out_total
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_last, out_empty, out_total
  );

endinterface

// File: rtl/lsb_finder.sv
// Combinational priority encoder: index of the lowest set bit, plus a found flag.
module lsb_finder
  import bitmask_enc_pkg::*;
(
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Walk downward so the lowest set bit is the last (winning) assignment.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = i[IW-1:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bitmask_index_encoder.sv
// Sequential 64-to-6 encoder: emits the index of every set bit of an accepted vector, one per beat.
// Define BITMASK_MSB_FIRST_EN to emit indices highest first instead of lowest first.
module bitmask_index_encoder
  import bitmask_enc_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  bitmask_index_encoder_if.slave  bus
);

  state_e        state_q, state_d;
  logic [W-1:0]  pending_q, pending_d;
  logic [CW-1:0] total_q, total_d;
  logic [W-1:0]  scan_vec;
  logic [IW-1:0] find_idx;
  logic [IW-1:0] sel_idx;
  logic          found;
  logic          one_left;

`ifdef BITMASK_MSB_FIRST_EN
  // Reversed input turns the lowest-bit finder into a highest-bit finder; ~idx maps it back.
  always_comb begin
    for (int i = 0; i < W; i++) begin
      scan_vec[i] = pending_q[W-1-i];
    end
    sel_idx = ~find_idx;
  end
`else
  always_comb begin
    scan_vec = pending_q;
    sel_idx  = find_idx;
  end
`endif

  lsb_finder u_lsb_finder (
    .vec   (scan_vec),
    .idx   (find_idx),
    .found (found)
  );

  assign one_left = ((pending_q & (pending_q - W'(1))) == '0);

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    total_d       = total_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_idx   = '0;
    bus.out_last  = 1'b0;
    bus.out_empty = 1'b0;
    bus.out_total = '0;
    unique case (state_q)
      StIdle: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          pending_d = bus.in_vec;
          total_d   = popcount(bus.in_vec);
          state_d   = (bus.in_vec == '0) ? StEmpty : StScan;
        end
      end
      StScan: begin
        bus.out_valid = found;
        bus.out_idx   = sel_idx;
        bus.out_last  = one_left;
        bus.out_total = total_q;
        if (found && bus.out_ready) begin
          pending_d = pending_q & ~(W'(1) << sel_idx);
          if (one_left) begin
            state_d = StIdle;
            total_d = '0;
          end
        end
      end
      StEmpty: begin
        bus.out_valid = 1'b1;
        bus.out_last  = 1'b1;
        bus.out_empty = 1'b1;
        bus.out_total = total_q;
        if (bus.out_ready) begin
          state_d = StIdle;
          total_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      pending_q <= '0;
      total_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      total_q   <= total_d;
    end
  end

endmodule

// File: tb/tb_bitmask_index_encoder.sv
// Self-checking bench for bitmask_index_encoder: vector table plus hand sequences, scoreboarded beats.
module tb_bitmask_index_encoder;
  import bitmask_enc_pkg::*;

  typedef struct {
    logic [5:0] idx;
    logic       last;
    logic       empty;
    logic [6:0] total;
  } beat_t;

  typedef struct {
    logic [63:0] vec;
    logic [6:0]  total;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic toggle_ready = 1'b0;
  int   checks = 0;
  int   errors = 0;
  beat_t sb[$];

  bitmask_index_encoder_if bus ();

  bitmask_index_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // out_ready changes just after each rising edge; constant 1 unless toggling is enabled.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = toggle_ready ? ~bus.out_ready : 1'b1;
    end
  end

  // Beat monitor: each visible beat is compared against the scoreboard head, popped on transfer.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got idx=%0d last=%0b empty=%0b total=%0d, want no beat",
                   bus.out_idx, bus.out_last, bus.out_empty, bus.out_total);
        end else begin
          e = sb[0];
          if (bus.out_idx !== e.idx || bus.out_last !== e.last || bus.out_empty !== e.empty ||
              bus.out_total !== e.total) begin
            errors++;
            $display("FAIL beat: got idx=%0d last=%0b empty=%0b total=%0d, want idx=%0d last=%0b empty=%0b total=%0d",
                     bus.out_idx, bus.out_last, bus.out_empty, bus.out_total,
                     e.idx, e.last, e.empty, e.total);
          end
          if (bus.out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic push_exp(input logic [63:0] v, input logic [6:0] total);
    beat_t b;
    int idxs[$];
    if (v == 64'h0) begin
      b.idx = 6'd0; b.last = 1'b1; b.empty = 1'b1; b.total = total;
      sb.push_back(b);
    end else begin
`ifdef BITMASK_MSB_FIRST_EN
      for (int i = 63; i >= 0; i--) if (v[i]) idxs.push_back(i);
`else
      for (int i = 0; i < 64; i++) if (v[i]) idxs.push_back(i);
`endif
      for (int k = 0; k < idxs.size(); k++) begin
        b.idx   = 6'(idxs[k]);
        b.last  = (k == idxs.size() - 1);
        b.empty = 1'b0;
        b.total = total;
        sb.push_back(b);
      end
    end
  endtask

  task automatic check(input string name, input logic ok, input logic [63:0] got,
                       input logic [63:0] want);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  // Called at posedge+1; leaves at posedge+1 just after the transfer edge.
  task automatic send(input logic [63:0] v, input logic [6:0] total);
    int n = 0;
    while (!bus.in_ready && n < 400) begin
      @(posedge clk); #1; n++;
    end
    check("send_ready_timeout", bus.in_ready, 64'(bus.in_ready), 64'h1);
    bus.in_valid = 1'b1;
    bus.in_vec   = v;
    push_exp(v, total);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge clk); #1; n++;
    end
    check({name, "_drain"}, sb.size() == 0, 64'(sb.size()), 64'h0);
    check({name, "_idle"}, bus.in_ready === 1'b1 && bus.out_valid === 1'b0,
          {62'h0, bus.in_ready, bus.out_valid}, 64'h2);
  endtask

  vec_t tbl[8];

  initial begin
    bus.in_valid = 1'b0;
    bus.in_vec   = 64'h0;
    tbl[0] = '{64'h1, 7'd1};
    tbl[1] = '{64'h8000_0000_0000_0001, 7'd2};
    tbl[2] = '{64'h0, 7'd0};
    tbl[3] = '{64'hF0, 7'd4};
    tbl[4] = '{64'hA5A5_0000_0000_0003, 7'd10};
    tbl[5] = '{64'h8000_0000_0000_0000, 7'd1};
    tbl[6] = '{64'h5, 7'd2};
    tbl[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 7'd64};

    #3;
    check("reset_outputs", bus.in_ready === 1'b1 && bus.out_valid === 1'b0 &&
          bus.out_idx === 6'd0 && bus.out_last === 1'b0 && bus.out_empty === 1'b0 &&
          bus.out_total === 7'd0,
          {48'h0, bus.in_ready, bus.out_valid, bus.out_idx, bus.out_last, bus.out_empty,
           bus.out_total}, {48'h0, 2'b10, 6'd0, 2'b00, 7'd0});
    @(posedge clk); #1;
    rst = 1'b0;

    // Single bit: first beat appears the cycle after acceptance.
    send(64'h1, 7'd1);
    check("latency_valid", bus.out_valid === 1'b1 && bus.in_ready === 1'b0,
          {62'h0, bus.out_valid, bus.in_ready}, 64'h2);
    check("latency_beat", bus.out_idx === 6'd0 && bus.out_last === 1'b1 && bus.out_total === 7'd1,
          {48'h0, bus.out_idx, bus.out_last, bus.out_total}, {48'h0, 6'd0, 1'b1, 7'd1});
    wait_idle("single");

    for (int t = 0; t < 8; t++) begin
      send(tbl[t].vec, tbl[t].total);
      wait_idle($sformatf("table%0d", t));
    end

    // All-ones with stalls; in_valid pulses mid-burst must be ignored.
    toggle_ready = 1'b1;
    send(64'hFFFF_FFFF_FFFF_FFFF, 7'd64);
    for (int k = 0; k < 6; k++) begin
      bus.in_valid = 1'b1;
      bus.in_vec   = 64'hDEAD_BEEF;
      check("busy_in_ready", bus.in_ready === 1'b0, 64'(bus.in_ready), 64'h0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    wait_idle("stall_burst");
    toggle_ready = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset after three beats discards the burst.
    send(64'hFFFF_FFFF_FFFF_FFFF, 7'd64);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("reset_mid_valid", bus.out_valid === 1'b0 && bus.in_ready === 1'b1 &&
          bus.out_total === 7'd0, {55'h0, bus.out_valid, bus.in_ready, bus.out_total},
          {55'h0, 2'b01, 7'd0});
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check("reset_release_ready", bus.in_ready === 1'b1, 64'(bus.in_ready), 64'h1);
    send(64'h10, 7'd1);
    check("post_reset_beat", bus.out_idx === 6'd4 && bus.out_last === 1'b1 &&
          bus.out_total === 7'd1, {48'h0, bus.out_idx, bus.out_last, bus.out_total},
          {48'h0, 6'd4, 1'b1, 7'd1});
    wait_idle("post_reset");

    check("scoreboard_empty", sb.size() == 0, 64'(sb.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
